// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock parameterised FIFO with occupancy flags and registered
//   handshake pulses (wr_ack / overflow / underflow).
//
//   Build option:
//     FIFO_FWFT_EN  defined   -> first-word-fall-through: data_out shows the
//                                head word whenever the FIFO is non-empty,
//                                and rd_en pops it (0-cycle read latency).
//                   undefined -> standard mode: data_out is a register loaded
//                                with the head word on an accepted read
//                                (1-cycle read latency) and held otherwise.
//
//   Ports:
//     clk          in   sole clock, rising edge
//     rst          in   synchronous active-high reset
//     data_in      in   [FIFO_WIDTH]  write data
//     wr_en        in   write request
//     rd_en        in   read request
//     data_out     out  [FIFO_WIDTH]  read data
//     wr_ack       out  previous-cycle write accepted (pulse)
//     overflow     out  previous-cycle write rejected (pulse)
//     underflow    out  previous-cycle read rejected (pulse)
//     full, empty, almostfull, almostempty   out  occupancy flags
//     count        out  [$clog2(FIFO_DEPTH)+1]  occupancy 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int FIFO_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          wr_ack,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          full,
    output logic                          empty,
    output logic                          almostfull,
    output logic                          almostempty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ack_q, wr_ack_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_acc, wr_acc;

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CW'(ALMOST_FULL_TH)) && !full;
    assign almostempty = (count_q <= CW'(ALMOST_EMPTY_TH)) && !empty;

    // A full FIFO still takes a write when a read frees the slot in the
    // same cycle; an empty FIFO never honours a read, even alongside a write.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ack_d    = wr_acc;
            overflow_d  = wr_en && !wr_acc;
            underflow_d = rd_en && !rd_acc;
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
        wr_ack_q    <= wr_ack_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
    end

    // Storage is not reset; a reset only needs to block the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;

    always_comb begin
        data_out_d = data_out_q;
        if (rst)         data_out_d = '0;
        else if (rd_acc) data_out_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;
`endif

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//   Self-checking bench for sync_fifo_param (WIDTH=16, DEPTH=8, default
//   thresholds). Reference model is a plain queue of words; expected flags
//   are derived from its size. Works for both read modes.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int W = 16;
    localparam int D = 8;
`ifdef FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] data_out;
    logic         wr_ack, overflow, underflow;
    logic         full, empty, almostfull, almostempty;
    logic [3:0]   count;

    sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .count       (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout;
    bit           m_ack, m_ovf, m_udf;

    typedef struct {
        bit           wr;
        bit           rd;
        logic [W-1:0] din;
        int           cnt;
        bit           full;
        bit           empty;
        bit           af;
        bit           ae;
        bit           ack;
        bit           ovf;
        bit           udf;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(bit wr, bit rd, logic [W-1:0] din, int cnt,
                                bit f, bit e, bit af, bit ae,
                                bit ack, bit ovf, bit udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
        v.full = f; v.empty = e; v.af = af; v.ae = ae;
        v.ack = ack; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_step(bit r, bit w, bit rd, logic [W-1:0] d);
        int sz;
        bit racc, wacc;
        if (r) begin
            mq.delete();
            m_dout = '0;
            m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            return;
        end
        sz   = mq.size();
        racc = rd && (sz > 0);
        wacc = w && ((sz < D) || racc);
        m_ack = wacc;
        m_ovf = w && !wacc;
        m_udf = rd && !racc;
        if (racc) m_dout = mq.pop_front();
        if (wacc) mq.push_back(d);
    endfunction

    function automatic logic [W-1:0] exp_dout();
        if (FWFT) return (mq.size() > 0) ? mq[0] : '0;
        return m_dout;
    endfunction

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, "_count"},  32'(count),       32'(sz));
        chk({tag, "_full"},   32'(full),        32'(sz == D));
        chk({tag, "_empty"},  32'(empty),       32'(sz == 0));
        chk({tag, "_afull"},  32'(almostfull),  32'(sz >= D - 1 && sz < D));
        chk({tag, "_aempty"}, 32'(almostempty), 32'(sz <= 1 && sz > 0));
        chk({tag, "_ack"},    32'(wr_ack),      32'(m_ack));
        chk({tag, "_ovf"},    32'(overflow),    32'(m_ovf));
        chk({tag, "_udf"},    32'(underflow),   32'(m_udf));
        chk({tag, "_dout"},   32'(data_out),    32'(exp_dout()));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the same point, well away from the next active edge.
    task automatic step(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
        rst = r; wr_en = w; rd_en = rd; data_in = d;
        @(posedge clk);
        model_step(r, w, rd, d);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        mq.delete(); m_dout = '0; m_ack = 0; m_ovf = 0; m_udf = 0;

        // ---------------- reset state ----------------
        step(1, 0, 0, '0);
        step(1, 1, 1, 16'hFFFF);
        check_model("reset");

        // ---------------- table: fill, overflow, drain, underflow, empty r+w ----------------
        for (int k = 1; k <= 8; k++)
            tbl[k-1] = mk(1, 0, W'(k), k, k == 8, 0, k == 7, k == 1, 1, 0, 0);
        tbl[8] = mk(1, 0, 16'hDEAD, 8, 1, 0, 0, 0, 0, 1, 0);
        for (int j = 1; j <= 8; j++)
            tbl[8+j] = mk(0, 1, '0, 8 - j, 0, j == 8, j == 1, j == 7, 0, 0, 0);
        tbl[17] = mk(0, 1, '0,       0, 0, 1, 0, 0, 0, 0, 1);
        tbl[18] = mk(1, 1, 16'h00AA, 1, 0, 0, 0, 1, 1, 0, 1);
        tbl[19] = mk(0, 0, '0,       1, 0, 0, 0, 1, 0, 0, 0);
        tbl[20] = mk(0, 1, '0,       0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            step(0, tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk($sformatf("tbl%0d_count", i), 32'(count),       32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_full", i),  32'(full),        32'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), 32'(empty),       32'(tbl[i].empty));
            chk($sformatf("tbl%0d_afull", i), 32'(almostfull),  32'(tbl[i].af));
            chk($sformatf("tbl%0d_aempty", i),32'(almostempty), 32'(tbl[i].ae));
            chk($sformatf("tbl%0d_ack", i),   32'(wr_ack),      32'(tbl[i].ack));
            chk($sformatf("tbl%0d_ovf", i),   32'(overflow),    32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_udf", i),   32'(underflow),   32'(tbl[i].udf));
            chk($sformatf("tbl%0d_dout", i),  32'(data_out),    32'(exp_dout()));
        end

        // ---------------- full with simultaneous write+read ----------------
        step(1, 0, 0, '0);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, W'(16'h0100 + k));
            check_model("fill");
        end
        step(0, 1, 1, 16'h00BB);
        check_model("full_rw");
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 1, '0);
            check_model("drain_bb");
        end

        // ---------------- reset mid-operation ----------------
        step(1, 0, 0, '0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, W'(16'h0A00 + k));
            check_model("pre_rst");
        end
        step(1, 1, 0, 16'h5555);
        check_model("mid_rst");
        step(0, 1, 0, 16'h1234);
        check_model("post_rst_wr");
        step(0, 0, 1, '0);
        check_model("post_rst_rd");
        step(0, 0, 0, '0);
        check_model("post_rst_idle");

        // ---------------- pointer wrap with steady write/read pairs ----------------
        step(1, 0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, W'($urandom));
            check_model("wrap_pre");
        end
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 1, W'($urandom));
            check_model("wrap_pair");
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, '0);
            check_model("wrap_drain");
        end

        // ---------------- randomized traffic with varying bias ----------------
        step(1, 0, 0, '0);
        for (int seg = 0; seg < 6; seg++) begin
            int pw, pr;
            pw = (seg % 3 == 0) ? 80 : (seg % 3 == 1) ? 20 : 50;
            pr = (seg % 3 == 0) ? 20 : (seg % 3 == 1) ? 80 : 50;
            for (int k = 0; k < 70; k++) begin
                bit r, w, rd;
                r  = ($urandom_range(0, 63) == 0);
                w  = ($urandom_range(0, 99) < pw);
                rd = ($urandom_range(0, 99) < pr);
                step(r, w, rd, W'($urandom));
                check_model("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
